// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen register bus and the APB bridge.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_READ         = 2'b00,
        RGGEN_POSTED_WRITE = 2'b01,
        RGGEN_WRITE        = 2'b11
    } rggen_direction;

    typedef enum logic [1:0] {
        RGGEN_OKAY          = 2'b00,
        RGGEN_SLAVE_ERROR   = 2'b10,
        RGGEN_TIMEOUT_ERROR = 2'b11
    } rggen_status;

    typedef enum logic [1:0] {
        BRIDGE_IDLE   = 2'b00,
        BRIDGE_SETUP  = 2'b01,
        BRIDGE_ACCESS = 2'b10,
        BRIDGE_DONE   = 2'b11
    } rggen_apb_bridge_state;

    // Posted and non-posted writes both drive PWRITE.
    function automatic logic rggen_is_write(input rggen_direction dir);
        return dir != RGGEN_READ;
    endfunction

endpackage

// File: rtl/rggen_apb_if.sv
// APB4 signal bundle.
interface rggen_apb_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
);
    logic                      psel;
    logic                      penable;
    logic [ADDRESS_WIDTH-1:0]  paddr;
    logic [2:0]                pprot;
    logic                      pwrite;
    logic [DATA_WIDTH-1:0]     pwdata;
    logic [DATA_WIDTH/8-1:0]   pstrb;
    logic                      pready;
    logic [DATA_WIDTH-1:0]     prdata;
    logic                      pslverr;

    modport master (
        output psel, penable, paddr, pprot, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pprot, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/rggen_bus_if.sv
// Internal register bus: one request in flight, completed by a single-cycle done.
interface rggen_bus_if
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
);
    logic                      request;
    logic [ADDRESS_WIDTH-1:0]  address;
    rggen_direction            direction;
    logic [DATA_WIDTH-1:0]     write_data;
    logic [DATA_WIDTH/8-1:0]   write_strobe;
    logic                      done;
    logic [DATA_WIDTH-1:0]     read_data;
    rggen_status               status;

    modport master (
        output request, address, direction, write_data, write_strobe,
        input  done, read_data, status
    );

    modport slave (
        input  request, address, direction, write_data, write_strobe,
        output done, read_data, status
    );
endinterface

// File: rtl/rggen_apb_bridge_timer.sv
// ACCESS-phase wait counter; expired flags the TIMEOUT_CYCLES-th cycle without pready.
module rggen_apb_bridge_timer #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (count && (r_count != CW'(TIMEOUT_CYCLES))) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = count && (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/rggen_apb_bridge.sv
// Register bus to APB4 initiator. Optional response timeout: RGGEN_APB_BRIDGE_TIMEOUT_EN.
module rggen_apb_bridge
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic         clk,
    input logic         rst_n,
    rggen_bus_if.slave  bus_if,
    rggen_apb_if.master apb_if
);
    localparam int STRB_W = DATA_WIDTH / 8;

    rggen_apb_bridge_state    r_state;
    logic                     r_psel;
    logic                     r_penable;
    logic                     r_pwrite;
    logic [ADDRESS_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0]    r_pwdata;
    logic [STRB_W-1:0]        r_pstrb;
    logic                     r_done;
    logic [DATA_WIDTH-1:0]    r_read_data;
    rggen_status              r_status;
    logic                     w_expired;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
    logic w_timer_clear;
    logic w_timer_count;

    // Clearing during SETUP means the count starts at zero on the first ACCESS cycle.
    assign w_timer_clear = (r_state == BRIDGE_SETUP);
    assign w_timer_count = (r_state == BRIDGE_ACCESS) && !apb_if.pready;

    rggen_apb_bridge_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_timer_clear),
        .count   (w_timer_count),
        .expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= BRIDGE_IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_done      <= 1'b0;
            r_read_data <= '0;
            r_status    <= RGGEN_OKAY;
        end else begin
            case (r_state)
                BRIDGE_IDLE: begin
                    if (bus_if.request) begin
                        r_paddr  <= bus_if.address;
                        r_pwrite <= rggen_is_write(bus_if.direction);
                        r_pwdata <= bus_if.write_data;
                        r_pstrb  <= rggen_is_write(bus_if.direction) ? bus_if.write_strobe : '0;
                        r_psel   <= 1'b1;
                        r_state  <= BRIDGE_SETUP;
                    end
                end
                BRIDGE_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= BRIDGE_ACCESS;
                end
                BRIDGE_ACCESS: begin
                    // A completing slave takes priority over a timeout in the same cycle.
                    if (apb_if.pready) begin
                        r_read_data <= r_pwrite ? '0 : apb_if.prdata;
                        r_status    <= apb_if.pslverr ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= BRIDGE_DONE;
                    end else if (w_expired) begin
                        r_read_data <= '0;
                        r_status    <= RGGEN_TIMEOUT_ERROR;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= BRIDGE_DONE;
                    end
                end
                BRIDGE_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= BRIDGE_IDLE;
                end
                default: begin
                    r_state <= BRIDGE_IDLE;
                end
            endcase
        end
    end

    assign apb_if.psel     = r_psel;
    assign apb_if.penable  = r_penable;
    assign apb_if.paddr    = r_paddr;
    assign apb_if.pprot    = 3'b000;
    assign apb_if.pwrite   = r_pwrite;
    assign apb_if.pwdata   = r_pwdata;
    assign apb_if.pstrb    = r_pstrb;
    assign bus_if.done      = r_done;
    assign bus_if.read_data = r_read_data;
    assign bus_if.status    = r_status;

endmodule

// File: tb/tb_rggen_apb_bridge.sv
// Self-checking bench for rggen_apb_bridge; acts as register-bus master and APB slave.
module tb_rggen_apb_bridge;
    import rggen_rtl_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_setup  = 0;

    always #5 clk = ~clk;

    rggen_bus_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();
    rggen_apb_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) apb_if ();

    rggen_apb_bridge #(
        .ADDRESS_WIDTH  (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus_if),
        .apb_if (apb_if)
    );

    // Number of APB transfers started (SETUP phases seen at a clock edge).
    always @(posedge clk) begin
        if (apb_if.psel && !apb_if.penable) n_setup <= n_setup + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One complete transfer, entered and left in an IDLE cycle at #1 after the edge.
    // The transfer takes waits+1 ACCESS cycles; with to=1 pready never comes (timeout).
    task automatic run_xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [3:0] s, input int waits, input bit err,
                            input logic [DW-1:0] prd, input bit to, input string tag);
        int          last;
        logic [2:0]  exp_ctrl;
        logic [DW-1:0] exp_rd;
        logic [1:0]  exp_st;
        logic [3:0]  exp_strb;
        last     = 3 + waits;
        exp_rd   = (to || wr) ? '0 : prd;
        exp_st   = to ? 2'b11 : (err ? 2'b10 : 2'b00);
        exp_strb = wr ? s : 4'h0;
        bus_if.request      = 1'b1;
        bus_if.address      = a;
        bus_if.direction    = wr ? (($urandom % 2) ? RGGEN_WRITE : RGGEN_POSTED_WRITE) : RGGEN_READ;
        bus_if.write_data   = d;
        bus_if.write_strobe = s;
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            exp_ctrl = (c == last) ? 3'b001 : ((c == 1) ? 3'b100 : 3'b110);
            n_checks++;
            if ({apb_if.psel, apb_if.penable, bus_if.done} !== exp_ctrl) begin
                $display("FAIL %s ctrl cycle %0d: psel/penable/done got %b want %b",
                         tag, c, {apb_if.psel, apb_if.penable, bus_if.done}, exp_ctrl);
            end else n_pass++;
            if (c < last) begin
                n_checks++;
                if ({apb_if.paddr, apb_if.pwrite, apb_if.pwdata, apb_if.pstrb, apb_if.pprot}
                    !== {a, wr, d, exp_strb, 3'b000}) begin
                    $display("FAIL %s payload cycle %0d: got %h/%b/%h/%h/%b want %h/%b/%h/%h/000",
                             tag, c, apb_if.paddr, apb_if.pwrite, apb_if.pwdata, apb_if.pstrb,
                             apb_if.pprot, a, wr, d, exp_strb);
                end else n_pass++;
            end else begin
                n_checks++;
                if ({bus_if.read_data, bus_if.status} !== {exp_rd, exp_st}) begin
                    $display("FAIL %s response: got %h/%b want %h/%b",
                             tag, bus_if.read_data, bus_if.status, exp_rd, exp_st);
                end else n_pass++;
                bus_if.request = 1'b0;
            end
            if (!to && (c == last - 1)) begin
                apb_if.pready  = 1'b1;
                apb_if.prdata  = prd;
                apb_if.pslverr = err;
            end else if (c >= 2 && c < last) begin
                apb_if.pready  = 1'b0;
                apb_if.prdata  = $urandom;
                apb_if.pslverr = $urandom;
            end else begin
                apb_if.pready  = $urandom;
                apb_if.prdata  = $urandom;
                apb_if.pslverr = $urandom;
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if ({apb_if.psel, apb_if.penable, bus_if.done, bus_if.read_data, bus_if.status}
            !== {3'b000, exp_rd, exp_st}) begin
            $display("FAIL %s hold: got %b%b%b/%h/%b want 000/%h/%b", tag, apb_if.psel,
                     apb_if.penable, bus_if.done, bus_if.read_data, bus_if.status, exp_rd, exp_st);
        end else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.request = 1'b0;
        bus_if.address = '0;
        bus_if.direction = RGGEN_READ;
        bus_if.write_data = '0;
        bus_if.write_strobe = '0;
        apb_if.pready = 1'b0;
        apb_if.prdata = '0;
        apb_if.pslverr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({apb_if.psel, apb_if.penable, apb_if.pwrite, bus_if.done, apb_if.paddr, apb_if.pwdata,
             apb_if.pstrb, bus_if.read_data, bus_if.status, apb_if.pprot} !== '0) begin
            $display("FAIL reset_values: got %b%b%b%b/%h/%h/%h/%h/%b want all zero", apb_if.psel,
                     apb_if.penable, apb_if.pwrite, bus_if.done, apb_if.paddr, apb_if.pwdata,
                     apb_if.pstrb, bus_if.read_data, bus_if.status);
        end else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({apb_if.psel, bus_if.done} !== 2'b00) begin
            $display("FAIL idle_after_reset: psel/done got %b want 00", {apb_if.psel, bus_if.done});
        end else n_pass++;
    endtask

    task automatic test_write_zero_wait();
        run_xfer(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 1'b0, $urandom, 1'b0, "write_zero_wait");
    endtask

    task automatic test_read_wait3();
        run_xfer(1'b0, 16'h0024, $urandom, 4'hF, 3, 1'b0, 32'h12345678, 1'b0, "read_wait3");
    endtask

    task automatic test_read_slverr();
        run_xfer(1'b0, 16'h0100, $urandom, $urandom, 1, 1'b1, 32'hCAFEF00D, 1'b0, "read_slverr");
    endtask

    task automatic test_back_to_back();
        int start;
        start = n_setup;
        run_xfer(1'b1, 16'h0200, 32'h0BADC0DE, 4'h3, 0, 1'b0, $urandom, 1'b0, "b2b_first");
        run_xfer(1'b0, 16'h0204, $urandom, 4'hF, 0, 1'b0, 32'hA5A5_5A5A, 1'b0, "b2b_second");
        n_checks++;
        if (n_setup - start !== 2) begin
            $display("FAIL b2b_transfer_count: got %0d want 2", n_setup - start);
        end else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            run_xfer($urandom % 2, $urandom, $urandom, $urandom, $urandom_range(0, 4),
                     $urandom % 2, $urandom, 1'b0, "random");
        end
    endtask

`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        run_xfer(1'b0, 16'h0300, $urandom, 4'hF, TO - 1, 1'b0, 32'h11112222, 1'b1, "timeout_read");
        run_xfer(1'b1, 16'h0304, 32'h33334444, 4'h5, TO - 1, 1'b0, $urandom, 1'b1, "timeout_write");
        run_xfer(1'b0, 16'h0308, $urandom, 4'hF, TO - 1, 1'b0, 32'h55556666, 1'b0, "ready_on_last");
    endtask
`else
    task automatic test_long_wait();
        run_xfer(1'b0, 16'h0300, $urandom, 4'hF, 40, 1'b0, 32'h77778888, 1'b0, "long_wait");
    endtask
`endif

    task automatic test_reset_mid();
        int bad;
        bus_if.request      = 1'b1;
        bus_if.address      = 16'h0400;
        bus_if.direction    = RGGEN_WRITE;
        bus_if.write_data   = 32'hFEEDFACE;
        bus_if.write_strobe = 4'hF;
        apb_if.pready       = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if ({apb_if.psel, apb_if.penable} !== 2'b11) begin
            $display("FAIL mid_reset_in_access: psel/penable got %b want 11",
                     {apb_if.psel, apb_if.penable});
        end else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({apb_if.psel, apb_if.penable, apb_if.pwrite, bus_if.done, apb_if.paddr,
             apb_if.pwdata, apb_if.pstrb, bus_if.read_data, bus_if.status} !== '0) begin
            $display("FAIL mid_reset_outputs: got %b%b%b%b/%h/%h/%h want all zero",
                     apb_if.psel, apb_if.penable, apb_if.pwrite, bus_if.done,
                     apb_if.paddr, apb_if.pwdata, bus_if.read_data);
        end else n_pass++;
        bus_if.request = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus_if.done || apb_if.psel) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            $display("FAIL mid_reset_no_done: got %0d active cycles want 0", bad);
        end else n_pass++;
        run_xfer(1'b0, 16'h0408, $urandom, 4'hF, 2, 1'b0, 32'h9999AAAA, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait3();
        test_read_slverr();
        test_back_to_back();
        test_random();
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
